// File: rtl/half_subtractor.sv
// Registered multi-lane 1-bit half subtractor (a - b per lane) with a
// saturating count of accepted vectors that produced any borrow.

module half_subtractor_lane (
    input  logic a,
    input  logic b,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b;
    assign borrow = ~a & b;
endmodule

module half_subtractor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] borrow,
    output logic             borrow_any,
    output logic [CNT_W-1:0] borrow_cnt
);
    localparam int STAGES = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic [WIDTH-1:0] borrow;
        logic             any;
    } rsp_t;

    req_t             req;
    rsp_t             rsp_c;
    rsp_t             rsp_q;
    logic [STAGES:0]  vld_pipe;
    logic [CNT_W-1:0] cnt_q;

    assign req.a = a;
    assign req.b = b;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_subtractor_lane u_lane (
            .a      (req.a[i]),
            .b      (req.b[i]),
            .diff   (rsp_c.diff[i]),
            .borrow (rsp_c.borrow[i])
        );
    end

    assign rsp_c.any = |rsp_c.borrow;

    assign vld_pipe[0] = in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        end
    end

    // Results only load on accepted vectors, so idle-cycle inputs never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_q <= '0;
        end else if (in_valid) begin
            rsp_q <= rsp_c;
        end
    end

    // Clear wins over the old count but still lets a same-cycle borrow count as one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= (in_valid && rsp_c.any) ? CNT_W'(1) : '0;
        end else if (in_valid && rsp_c.any && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid  = vld_pipe[STAGES];
    assign diff       = rsp_q.diff;
    assign borrow     = rsp_q.borrow;
    assign borrow_any = rsp_q.any;
    assign borrow_cnt = cnt_q;
endmodule

// File: tb/tb_half_subtractor.sv
// Directed bench: a 1-lane/2-bit-counter instance driven from a vector table,
// and a 4-lane instance exercised by hand-written sequences.

module tb_half_subtractor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, clr1, a1, b1;
    logic       ov1, d1, br1, any1;
    logic [1:0] cnt1;
    logic       v4, clr4;
    logic [3:0] a4, b4, d4, br4;
    logic       ov4, any4;
    logic [7:0] cnt4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    half_subtractor #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cnt_clr(clr1),
        .out_valid(ov1), .diff(d1), .borrow(br1), .borrow_any(any1), .borrow_cnt(cnt1)
    );

    half_subtractor #(.WIDTH(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cnt_clr(clr4),
        .out_valid(ov4), .diff(d4), .borrow(br4), .borrow_any(any4), .borrow_cnt(cnt4)
    );

    typedef struct {
        logic       a, b, v, clr;
        logic       d, br, any, ov;
        logic [1:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic a, logic b, logic v, logic clr,
                                logic d, logic br, logic any, logic ov, logic [1:0] cnt);
        vec_t t;
        t.a = a; t.b = b; t.v = v; t.clr = clr;
        t.d = d; t.br = br; t.any = any; t.ov = ov; t.cnt = cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic ov, input logic d, input logic br,
                        input logic any, input logic [1:0] cnt);
        chk({tag, ".ov"},  {31'd0, ov1},  {31'd0, ov});
        chk({tag, ".d"},   {31'd0, d1},   {31'd0, d});
        chk({tag, ".br"},  {31'd0, br1},  {31'd0, br});
        chk({tag, ".any"}, {31'd0, any1}, {31'd0, any});
        chk({tag, ".cnt"}, {30'd0, cnt1}, {30'd0, cnt});
    endtask

    initial begin
        // table: a b v clr | diff borrow any out_valid cnt
        // exhaustive truth table
        tbl.push_back(mk(0,0,1,0, 0,0,0,1, 2'd0));
        tbl.push_back(mk(0,1,1,0, 1,1,1,1, 2'd1));
        tbl.push_back(mk(1,0,1,0, 1,0,0,1, 2'd1));
        tbl.push_back(mk(1,1,1,0, 0,0,0,1, 2'd1));
        // hold while idle; idle inputs that would borrow must not count
        tbl.push_back(mk(1,0,1,0, 1,0,0,1, 2'd1));
        tbl.push_back(mk(0,1,0,0, 1,0,0,0, 2'd1));
        tbl.push_back(mk(0,1,0,0, 1,0,0,0, 2'd1));
        tbl.push_back(mk(0,1,0,0, 1,0,0,0, 2'd1));
        // clear while idle, then saturation at 3
        tbl.push_back(mk(0,1,0,1, 1,0,0,0, 2'd0));
        tbl.push_back(mk(0,1,1,0, 1,1,1,1, 2'd1));
        tbl.push_back(mk(0,1,1,0, 1,1,1,1, 2'd2));
        tbl.push_back(mk(0,1,1,0, 1,1,1,1, 2'd3));
        tbl.push_back(mk(0,1,1,0, 1,1,1,1, 2'd3));
        tbl.push_back(mk(0,1,1,0, 1,1,1,1, 2'd3));
        // clear with a borrowing vector -> 1; clear with non-borrowing -> 0
        tbl.push_back(mk(0,1,1,1, 1,1,1,1, 2'd1));
        tbl.push_back(mk(1,1,1,1, 0,0,0,1, 2'd0));

        // reset held 2 cycles with a live vector on the inputs
        rst_n = 1'b0;
        v1 = 1'b1; clr1 = 1'b0; a1 = 1'b1; b1 = 1'b1;
        v4 = 1'b1; clr4 = 1'b0; a4 = 4'hF; b4 = 4'hF;
        step();
        step();
        chk1("rst", 0, 0, 0, 0, 2'd0);
        chk("rst.ov4",  {31'd0, ov4},  32'd0);
        chk("rst.d4",   {28'd0, d4},   32'd0);
        chk("rst.br4",  {28'd0, br4},  32'd0);
        chk("rst.any4", {31'd0, any4}, 32'd0);
        chk("rst.cnt4", {24'd0, cnt4}, 32'd0);
        rst_n = 1'b1;
        v1 = 1'b0; v4 = 1'b0;
        step();
        chk("post_rst.ov", {31'd0, ov1}, 32'd0);

        foreach (tbl[i]) begin
            a1 = tbl[i].a; b1 = tbl[i].b; v1 = tbl[i].v; clr1 = tbl[i].clr;
            step();
            chk1($sformatf("vec%0d", i), tbl[i].ov, tbl[i].d, tbl[i].br, tbl[i].any, tbl[i].cnt);
        end
        v1 = 1'b0; clr1 = 1'b0;

        // 4-lane: mixed lanes, then all-borrow, then no borrow
        a4 = 4'b0101; b4 = 4'b0011; v4 = 1'b1;
        step();
        chk("w4a.ov",  {31'd0, ov4},  32'd1);
        chk("w4a.d",   {28'd0, d4},   32'b0110);
        chk("w4a.br",  {28'd0, br4},  32'b0010);
        chk("w4a.any", {31'd0, any4}, 32'd1);
        chk("w4a.cnt", {24'd0, cnt4}, 32'd1);
        a4 = 4'b0000; b4 = 4'b1111;
        step();
        chk("w4b.d",   {28'd0, d4},   32'hF);
        chk("w4b.br",  {28'd0, br4},  32'hF);
        chk("w4b.cnt", {24'd0, cnt4}, 32'd2);
        a4 = 4'b1100; b4 = 4'b1000;
        step();
        chk("w4c.d",   {28'd0, d4},   32'b0100);
        chk("w4c.br",  {28'd0, br4},  32'd0);
        chk("w4c.any", {31'd0, any4}, 32'd0);
        chk("w4c.cnt", {24'd0, cnt4}, 32'd2);
        v4 = 1'b0;
        step();
        chk("w4d.ov",  {31'd0, ov4},  32'd0);
        chk("w4d.d",   {28'd0, d4},   32'b0100);

        // mid-stream reset discards the in-flight result and the count
        a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
        step();
        chk1("mid.pre", 1, 1, 1, 1, 2'd1);
        rst_n = 1'b0;
        step();
        chk1("mid.rst", 0, 0, 0, 0, 2'd0);
        rst_n = 1'b1; v1 = 1'b0;
        step();
        chk1("mid.idle", 0, 0, 0, 0, 2'd0);
        a1 = 1'b1; b1 = 1'b0; v1 = 1'b1;
        step();
        chk1("mid.resume", 1, 1, 0, 0, 2'd0);
        v1 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
